// File: rtl/regfile_fifo_nxm.sv
// Show-ahead synchronous FIFO over a 2^AW x DW register file with an occupancy counter,
// full/empty, programmable almost-full/almost-empty flags and sticky overflow/underflow errors.
module regfile_fifo_nxm #(
    parameter int AW        = 3,
    parameter int DW        = 8,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wen_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          ren_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          afull_o,
    output logic          aempty_o,
    output logic [AW:0]   level_o,
    output logic          ovf_o,
    output logic          udf_o,
    input  logic          clr_err_i
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]   DEPTH_LV  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AFULL_LV  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0]   AEMPTY_LV = (AW+1)'(AEMPTY_TH);
    localparam logic [AW:0]   LV_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [DW-1:0]    mem_reg [DEPTH];
    logic [AW-1:0]    wptr_reg, wptr_next;
    logic [AW-1:0]    rptr_reg, rptr_next;
    logic [AW:0]      level_reg, level_next;
    logic             ovf_reg, ovf_next;
    logic             udf_reg, udf_next;
    logic             push_ok, pop_ok;
    logic [DEPTH-1:0] entry_we;

    // A push while full is only legal because the simultaneous pop frees the head slot.
    assign push_ok = wen_i & (~full_o | ren_i);
    assign pop_ok  = ren_i & ~empty_o;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign entry_we[gi] = push_ok & (wptr_reg == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_we[i]) mem_reg[i] <= wdata_i;
        end
    end

    always_comb begin
        wptr_next  = push_ok ? wptr_reg + PTR_ONE : wptr_reg;
        rptr_next  = pop_ok  ? rptr_reg + PTR_ONE : rptr_reg;
        level_next = level_reg;
        case ({push_ok, pop_ok})
            2'b10:   level_next = level_reg + LV_ONE;
            2'b01:   level_next = level_reg - LV_ONE;
            default: level_next = level_reg;
        endcase
        // Setting an error takes priority over clearing it in the same cycle.
        ovf_next = ovf_reg;
        if (wen_i & full_o & ~ren_i) ovf_next = 1'b1;
        else if (clr_err_i)          ovf_next = 1'b0;
        udf_next = udf_reg;
        if (ren_i & empty_o)         udf_next = 1'b1;
        else if (clr_err_i)          udf_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            level_reg <= '0;
            ovf_reg   <= 1'b0;
            udf_reg   <= 1'b0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            level_reg <= level_next;
            ovf_reg   <= ovf_next;
            udf_reg   <= udf_next;
        end
    end

    // Flags come only from the registered level, so no input reaches an output combinationally.
    assign full_o   = (level_reg == DEPTH_LV);
    assign empty_o  = (level_reg == '0);
    assign afull_o  = (level_reg >= AFULL_LV);
    assign aempty_o = (level_reg <= AEMPTY_LV);
    assign level_o  = level_reg;
    assign ovf_o    = ovf_reg;
    assign udf_o    = udf_reg;
    assign rdata_o  = empty_o ? '0 : mem_reg[rptr_reg];

endmodule

// File: tb/tb_regfile_fifo_nxm.sv
// Bench for regfile_fifo_nxm: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_regfile_fifo_nxm;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int AFULL_TH = 6;
    localparam int AEMPTY_TH = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wen_i = 1'b0;
    logic [DW-1:0] wdata_i = '0;
    logic          ren_i = 1'b0;
    logic          clr_err_i = 1'b0;
    logic [DW-1:0] rdata_o;
    logic          full_o, empty_o, afull_o, aempty_o, ovf_o, udf_o;
    logic [AW:0]   level_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_q[$];
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;
    bit         model_valid = 1'b0;

    regfile_fifo_nxm #(.AW(AW), .DW(DW), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)) dut (
        .clk(clk), .rst_n(rst_n), .wen_i(wen_i), .wdata_i(wdata_i), .ren_i(ren_i),
        .rdata_o(rdata_o), .full_o(full_o), .empty_o(empty_o), .afull_o(afull_o),
        .aempty_o(aempty_o), .level_o(level_o), .ovf_o(ovf_o), .udf_o(udf_o),
        .clr_err_i(clr_err_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock transaction: drive, take the edge, advance the model from the FIFO rules.
    task automatic step(input logic r, input logic w, input logic [7:0] d,
                        input logic rd, input logic c);
        bit m_full, m_empty;
        rst_n = r; wen_i = w; wdata_i = d; ren_i = rd; clr_err_i = c;
        @(posedge clk);
        if (!r) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            model_valid = 1'b1;
        end else begin
            m_full  = (m_q.size() == DEPTH);
            m_empty = (m_q.size() == 0);
            if (rd && !m_empty) void'(m_q.pop_front());
            if (w && (!m_full || rd)) m_q.push_back(d);
            m_ovf = (w && m_full && !rd) ? 1'b1 : (c ? 1'b0 : m_ovf);
            m_udf = (rd && m_empty)      ? 1'b1 : (c ? 1'b0 : m_udf);
        end
        #1;
        $display("txn t=%0t rst_n=%b wen=%b wdata=%h ren=%b clr=%b -> level=%0d rdata=%h full=%b empty=%b ovf=%b udf=%b",
                 $time, r, w, d, rd, c, level_o, rdata_o, full_o, empty_o, ovf_o, udf_o);
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            chk("level",  32'(level_o),  32'(m_q.size()));
            chk("empty",  32'(empty_o),  32'(m_q.size() == 0));
            chk("full",   32'(full_o),   32'(m_q.size() == DEPTH));
            chk("afull",  32'(afull_o),  32'(m_q.size() >= AFULL_TH));
            chk("aempty", 32'(aempty_o), 32'(m_q.size() <= AEMPTY_TH));
            chk("rdata",  32'(rdata_o),  (m_q.size() == 0) ? 32'h0 : 32'(m_q[0]));
            chk("ovf",    32'(ovf_o),    32'(m_ovf));
            chk("udf",    32'(udf_o),    32'(m_udf));
        end
    end

    initial begin
        logic [7:0] exp_byte;
        logic [7:0] last_pop;
        int pushed;
        int popped;

        // 1: reset state
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_empty", 32'(empty_o), 32'h1);
        chk("rst_aempty", 32'(aempty_o), 32'h1);
        chk("rst_full", 32'(full_o), 32'h0);
        chk("rst_afull", 32'(afull_o), 32'h0);
        chk("rst_level", 32'(level_o), 32'h0);
        chk("rst_rdata", 32'(rdata_o), 32'h00);
        chk("rst_ovf", 32'(ovf_o), 32'h0);
        chk("rst_udf", 32'(udf_o), 32'h0);

        // 2: fill with 0x11..0x88 then drain in order
        for (int i = 1; i <= 8; i++) begin
            exp_byte = 8'(i * 17);
            step(1'b1, 1'b1, exp_byte, 1'b0, 1'b0);
            chk("fill_level", 32'(level_o), 32'(i));
        end
        chk("fill_full", 32'(full_o), 32'h1);
        chk("fill_afull", 32'(afull_o), 32'h1);
        chk("fill_head", 32'(rdata_o), 32'h11);
        for (int i = 1; i <= 8; i++) begin
            exp_byte = 8'(i * 17);
            chk("drain_data", 32'(rdata_o), 32'(exp_byte));
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(empty_o), 32'h1);
        chk("drain_rdata", 32'(rdata_o), 32'h00);

        // 3: overflow while full, then clear
        for (int i = 1; i <= 8; i++) begin
            exp_byte = 8'(i * 17);
            step(1'b1, 1'b1, exp_byte, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf_o), 32'h1);
        chk("ovf_level", 32'(level_o), 32'h8);
        chk("ovf_head", 32'(rdata_o), 32'h11);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(ovf_o), 32'h0);

        // 4: push+pop while full
        step(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0);
        chk("pp_level", 32'(level_o), 32'h8);
        chk("pp_head", 32'(rdata_o), 32'h22);
        chk("pp_ovf", 32'(ovf_o), 32'h0);
        last_pop = 8'h00;
        for (int i = 0; i < 8; i++) begin
            last_pop = rdata_o;
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("pp_last", 32'(last_pop), 32'hAA);
        chk("pp_empty", 32'(empty_o), 32'h1);

        // 5: push+pop on empty with clear in the same cycle
        step(1'b1, 1'b1, 8'h5C, 1'b1, 1'b1);
        chk("udf_set", 32'(udf_o), 32'h1);
        chk("udf_level", 32'(level_o), 32'h1);
        chk("udf_rdata", 32'(rdata_o), 32'h5C);
        chk("udf_aempty", 32'(aempty_o), 32'h1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("udf_clr", 32'(udf_o), 32'h0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // 6: wrap at level 3 with an incrementing pattern, then reset mid-stream
        pushed = 0;
        popped = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'(8'h30 + pushed), 1'b0, 1'b0);
            pushed++;
        end
        chk("wrap_pre_aempty", 32'(aempty_o), 32'h0);
        for (int i = 0; i < 20; i++) begin
            chk("wrap_head", 32'(rdata_o), 32'(8'h30 + popped));
            step(1'b1, 1'b1, 8'(8'h30 + pushed), 1'b1, 1'b0);
            pushed++;
            popped++;
            chk("wrap_level", 32'(level_o), 32'h3);
        end
        chk("wrap_final_head", 32'(rdata_o), 32'h44);
        step(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
        chk("mid_rst_level", 32'(level_o), 32'h0);
        chk("mid_rst_empty", 32'(empty_o), 32'h1);
        chk("mid_rst_rdata", 32'(rdata_o), 32'h00);
        step(1'b1, 1'b1, 8'hE1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hE2, 1'b0, 1'b0);
        chk("post_rst_head", 32'(rdata_o), 32'hE1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_next", 32'(rdata_o), 32'hE2);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
